uart_tx_fifo: RTL and testbench

- Synchronous transmit FIFO between the APB register interface and the asynchronous UART transmitter. Used when TX_FIFO=1.
- The CPU side pushes bytes with a write strobe.
- The transmitter samples EMPTY while idle, pulses RD_N low for one cycle, and loads DATA_OUT two cycles later.
- Provides level, full/empty and sticky overflow status for the register block.

---
 rtl/uart_tx_fifo.sv | 107 ++++++++++
 tb/tb_uart_tx_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO between the APB register block and the UART transmitter.
// Registered read data, level, full/empty and sticky overflow status.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLEAR,
  input  logic             WE,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             RD_N,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             EMPTY,
  output logic             FULL,
  output logic [AW:0]      LEVEL,
  output logic             OVERFLOW
);

  localparam logic [AW:0] LVL_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             rd_ok, wr_ok, mem_we;

  // Next-state: reset beats clear, clear beats the strobes
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    empty_d = empty_q;
    full_d  = full_q;
    rd_ok   = !RD_N && !empty_q;
    wr_ok   = WE && (!full_q || rd_ok);
    mem_we  = 1'b0;
    if (RESET) begin
      wp_d    = '0;
      rp_d    = '0;
      level_d = '0;
      dout_d  = '0;
      ovf_d   = 1'b0;
      empty_d = 1'b1;
      full_d  = 1'b0;
    end else if (CLEAR) begin
      wp_d    = '0;
      rp_d    = '0;
      level_d = '0;
      ovf_d   = 1'b0;
      empty_d = 1'b1;
      full_d  = 1'b0;
    end else begin
      mem_we = wr_ok;
      if (rd_ok) begin
        dout_d = mem[rp_q];
        rp_d   = rp_q + 1'b1;
      end
      if (wr_ok) begin
        wp_d = wp_q + 1'b1;
      end
      if (WE && !wr_ok) begin
        ovf_d = 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        level_d = level_q + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        level_d = level_q - 1'b1;
      end
      empty_d = (level_d == '0);
      full_d  = (level_d == LVL_MAX);
    end
  end

  // Control and status registers
  always_ff @(posedge CLK) begin
    wp_q    <= wp_d;
    rp_q    <= rp_d;
    level_q <= level_d;
    dout_q  <= dout_d;
    ovf_q   <= ovf_d;
    empty_q <= empty_d;
    full_q  <= full_d;
  end

  // Storage array, never reset
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[wp_q] <= DATA_IN;
    end
  end

  assign DATA_OUT = dout_q;
  assign EMPTY    = empty_q;
  assign FULL     = full_q;
  assign LEVEL    = level_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table, directed corner cases,
// and random traffic against a queue-based reference.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       CLK = 1'b0;
  logic       RESET, CLEAR, WE, RD_N;
  logic [7:0] DATA_IN;
  logic [7:0] DATA_OUT;
  logic       EMPTY, FULL, OVERFLOW;
  logic [4:0] LEVEL;

  int passed = 0;
  int total  = 0;

  logic [7:0] mq [$];
  logic [7:0] m_dout;
  logic       m_ovf;

  uart_tx_fifo #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
    .CLK(CLK), .RESET(RESET), .CLEAR(CLEAR), .WE(WE),
    .DATA_IN(DATA_IN), .RD_N(RD_N), .DATA_OUT(DATA_OUT),
    .EMPTY(EMPTY), .FULL(FULL), .LEVEL(LEVEL), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      passed++;
  endtask

  // Reference: a queue of stored words plus read-data and overflow
  task automatic model(input logic r, c, w, input logic [7:0] d,
                       input logic rn);
    bit rd, wr;
    if (r) begin
      mq.delete(); m_dout = 8'h00; m_ovf = 1'b0;
    end else if (c) begin
      mq.delete(); m_ovf = 1'b0;
    end else begin
      rd = !rn && (mq.size() > 0);
      wr = w && ((mq.size() < DEPTH) || rd);
      if (rd) m_dout = mq.pop_front();
      if (w && !wr) m_ovf = 1'b1;
      if (wr) mq.push_back(d);
    end
  endtask

  task automatic apply(input logic r, c, w, input logic [7:0] d,
                       input logic rn);
    RESET = r; CLEAR = c; WE = w; DATA_IN = d; RD_N = rn;
    @(posedge CLK);
    model(r, c, w, d, rn);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".dout"},  32'(DATA_OUT), 32'(m_dout));
    chk({nm, ".level"}, 32'(LEVEL),    32'(mq.size()));
    chk({nm, ".empty"}, 32'(EMPTY),    32'(mq.size() == 0));
    chk({nm, ".full"},  32'(FULL),     32'(mq.size() == DEPTH));
    chk({nm, ".ovf"},   32'(OVERFLOW), 32'(m_ovf));
  endtask

  typedef struct {
    logic       r, c, w;
    logic [7:0] d;
    logic       rn;
    logic [7:0] e_dout;
    logic [4:0] e_lvl;
    logic       e_emp, e_full, e_ovf;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [7:0] last;
    bit         saw_ff;
    int         wb;
    logic       r, c, w, rn;
    logic [7:0] d;

    RESET = 1'b1; CLEAR = 1'b0; WE = 1'b0; DATA_IN = 8'h00; RD_N = 1'b1;
    m_dout = 8'h00; m_ovf = 1'b0;

    //      r    c    w    d      rn   dout   lvl  emp  full ovf
    tbl[0] = '{1'b1,1'b0,1'b0,8'h00,1'b1,8'h00,5'd0,1'b1,1'b0,1'b0};
    tbl[1] = '{1'b0,1'b0,1'b1,8'h41,1'b1,8'h00,5'd1,1'b0,1'b0,1'b0};
    tbl[2] = '{1'b0,1'b0,1'b1,8'h42,1'b1,8'h00,5'd2,1'b0,1'b0,1'b0};
    tbl[3] = '{1'b0,1'b0,1'b1,8'h43,1'b1,8'h00,5'd3,1'b0,1'b0,1'b0};
    tbl[4] = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h41,5'd2,1'b0,1'b0,1'b0};
    tbl[5] = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h42,5'd1,1'b0,1'b0,1'b0};
    tbl[6] = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h43,5'd0,1'b1,1'b0,1'b0};
    tbl[7] = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h43,5'd0,1'b1,1'b0,1'b0};
    tbl[8] = '{1'b0,1'b0,1'b1,8'h5C,1'b0,8'h43,5'd1,1'b0,1'b0,1'b0};
    tbl[9] = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h5C,5'd0,1'b1,1'b0,1'b0};

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].r, tbl[i].c, tbl[i].w, tbl[i].d, tbl[i].rn);
      chk($sformatf("vec%0d.dout", i),  32'(DATA_OUT), 32'(tbl[i].e_dout));
      chk($sformatf("vec%0d.level", i), 32'(LEVEL),    32'(tbl[i].e_lvl));
      chk($sformatf("vec%0d.empty", i), 32'(EMPTY),    32'(tbl[i].e_emp));
      chk($sformatf("vec%0d.full", i),  32'(FULL),     32'(tbl[i].e_full));
      chk($sformatf("vec%0d.ovf", i),   32'(OVERFLOW), 32'(tbl[i].e_ovf));
    end

    // Fill, overflow with 0xFF, drain in order
    apply(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) apply(1'b0, 1'b0, 1'b1, 8'(i), 1'b1);
    chk("fill.full", 32'(FULL), 32'd1);
    chk("fill.level", 32'(LEVEL), 32'd16);
    chk("fill.ovf", 32'(OVERFLOW), 32'd0);
    apply(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
    chk("ovf.set", 32'(OVERFLOW), 32'd1);
    chk("ovf.level", 32'(LEVEL), 32'd16);
    saw_ff = 1'b0;
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk($sformatf("drain%0d", i), 32'(DATA_OUT), 32'(i));
      if (DATA_OUT == 8'hFF) saw_ff = 1'b1;
    end
    chk("drain.no_ff", 32'(saw_ff), 32'd0);
    chk("drain.empty", 32'(EMPTY), 32'd1);
    chk("drain.ovf_sticky", 32'(OVERFLOW), 32'd1);
    chk_model("drain");

    // Full with simultaneous read and write
    apply(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) apply(1'b0, 1'b0, 1'b1, 8'(i), 1'b1);
    apply(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0);
    chk("fullrw.dout", 32'(DATA_OUT), 32'h00);
    chk("fullrw.level", 32'(LEVEL), 32'd16);
    chk("fullrw.full", 32'(FULL), 32'd1);
    chk("fullrw.ovf", 32'(OVERFLOW), 32'd0);
    last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk_model($sformatf("fullrw.drain%0d", i));
      last = DATA_OUT;
    end
    chk("fullrw.last", 32'(last), 32'hAA);

    // Wrap-around: 10 in, 10 out, 10 in, 10 out
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 10; i++) begin
        apply(1'b0, 1'b0, 1'b1, 8'(8'h30 + p*16 + i), 1'b1);
        chk($sformatf("wrap%0d.wlvl%0d", p, i), 32'(LEVEL), 32'(i + 1));
      end
      for (int i = 0; i < 10; i++) begin
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk($sformatf("wrap%0d.rd%0d", p, i), 32'(DATA_OUT),
            32'(8'h30 + p*16 + i));
        chk($sformatf("wrap%0d.rlvl%0d", p, i), 32'(LEVEL), 32'(9 - i));
      end
    end

    // CLEAR with WE at LEVEL=5 and OVERFLOW=1, then RESET mid-stream
    for (int i = 0; i < 16; i++) apply(1'b0, 1'b0, 1'b1, 8'(8'h80 + i), 1'b1);
    apply(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1);
    for (int i = 0; i < 11; i++) apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("pre_clr.level", 32'(LEVEL), 32'd5);
    chk("pre_clr.ovf", 32'(OVERFLOW), 32'd1);
    apply(1'b0, 1'b1, 1'b1, 8'h77, 1'b1);
    chk("clr.level", 32'(LEVEL), 32'd0);
    chk("clr.empty", 32'(EMPTY), 32'd1);
    chk("clr.ovf", 32'(OVERFLOW), 32'd0);
    chk("clr.dout_hold", 32'(DATA_OUT), 32'h8A);
    idle();
    chk("clr.dropped", 32'(LEVEL), 32'd0);
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b1, 8'(8'h60 + i), 1'b1);
    apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("mid.dout", 32'(DATA_OUT), 32'h60);
    apply(1'b1, 1'b0, 1'b1, 8'h99, 1'b0);
    chk("rst.dout", 32'(DATA_OUT), 32'h00);
    chk("rst.level", 32'(LEVEL), 32'd0);
    chk("rst.empty", 32'(EMPTY), 32'd1);
    chk("rst.full", 32'(FULL), 32'd0);
    chk("rst.ovf", 32'(OVERFLOW), 32'd0);
    chk_model("rst");

    // Random traffic, alternating write-heavy and read-heavy phases
    for (int i = 0; i < 3000; i++) begin
      wb = ((i / 300) % 2) ? 30 : 75;
      r  = ($urandom_range(0, 399) == 0);
      c  = ($urandom_range(0, 249) == 0);
      w  = ($urandom_range(0, 99) < wb);
      rn = !($urandom_range(0, 99) < 50);
      d  = 8'($urandom);
      apply(r, c, w, d, rn);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
